dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port data memory.
- Typical requesters: the CPU load/store stage (r0) and a debug/loader port (r1).
- Accepts requests with a valid/ready handshake, grants round-robin, and drives the memory's address/data/MemRead/MemWrite/Funct3 inputs.
- Captures the memory's registered read data one cycle after issue and returns it to the granted requester.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter_rr_arb2.sv | 36 +++
 rtl/dmem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter slice. It holds the memory
// geometry, the funct3 code the memory implements, the arbiter FSM state type
// and the requester grant id type.
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int         MEM_WORDS   = 64;
  localparam int         MEM_BYTES   = 4 * MEM_WORDS;
  localparam logic [2:0] FUNCT3_BYTE = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Grant id: 0 = requester 0 (CPU), 1 = requester 1 (debug/loader).
  typedef logic gid_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Requester-side bundle of the data-memory arbiter. There is one instance per
// requester.
//   valid  : request pending (requester -> arbiter)
//   ready  : request accepted this cycle (arbiter -> requester)
//   we     : 1 = store, 0 = load
//   addr   : byte address
//   wdata  : store data, byte in [7:0]
//   funct3 : access size code
//   rvalid : load data valid, one-cycle pulse (arbiter -> requester)
//   rdata  : load data, held until the next load completion
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        funct3;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, we, addr, wdata, funct3,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata, funct3,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin pick. The logic is purely combinational; the
// last_grant history register lives in the parent.
//   req[1:0]   : request vector (bit i = requester i)
//   last_grant : id of the most recently accepted requester
//   en         : allow a grant this cycle
//   grant      : winning id (meaningful when any req is set)
//   gnt[1:0]   : one-hot grant, all zero when en is low or nothing requests
// -----------------------------------------------------------------------------
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  gid_t       last_grant,
  input  logic       en,
  output gid_t       grant,
  output logic [1:0] gnt
);

  always_comb begin
    grant = 1'b0;
    // On a tie the requester that did not win last time goes first.
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req == 2'b10) begin
      grant = 1'b1;
    end

    gnt = 2'b00;
    if (en && (req != 2'b00)) begin
      gnt = grant ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester round-robin arbiter and sequencer in front of the single-port
// data memory. A request is accepted in IDLE. The next cycle (ISSUE) drives
// the memory for one cycle. For a load, the memory's registered read data is
// captured in WAIT and returned as a one-cycle rvalid pulse.
//   clk        : system clock
//   reset      : synchronous, active-low
//   r0, r1     : requester ports (dmem_arbiter_if.slave)
//   mem_addr   : memory byte address (MemSum), 0 outside ISSUE
//   mem_wdata  : memory WriteData, 0 outside ISSUE
//   mem_read   : memory MemRead, one cycle per load
//   mem_write  : memory MemWrite, one cycle per store
//   mem_funct3 : memory Funct3, 0 outside ISSUE
//   mem_rdata  : memory ReadData (registered by the memory)
//   busy       : FSM not in IDLE
//   err        : present only with DMEM_ARB_ADDR_CHECK_EN. Pulses for a
//                request whose address falls outside the memory.
// Build option: `define DMEM_ARB_ADDR_CHECK_EN turns on out-of-range
// address rejection and adds the err output.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     r0,
  dmem_arbiter_if.slave     r1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef DMEM_ARB_ADDR_CHECK_EN
  ,
  output logic              err
`endif
);

  state_t            state;
  gid_t              last_grant;
  gid_t              gid_q;
  logic              we_q;
  logic              bad_q;

  gid_t              win_id;
  logic [1:0]        gnt;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_funct3;
  logic              sel_bad;

  rr_arb2 u_arb (
    .req        ({r1.valid, r0.valid}),
    .last_grant (last_grant),
    .en         (reset && (state == IDLE)),
    .grant      (win_id),
    .gnt        (gnt)
  );

  // ready is the only combinational output and is asserted only in IDLE.
  assign r0.ready = gnt[0];
  assign r1.ready = gnt[1];
  assign accept   = |gnt;

  assign sel_we     = win_id ? r1.we     : r0.we;
  assign sel_addr   = win_id ? r1.addr   : r0.addr;
  assign sel_wdata  = win_id ? r1.wdata  : r0.wdata;
  assign sel_funct3 = win_id ? r1.funct3 : r0.funct3;

`ifdef DMEM_ARB_ADDR_CHECK_EN
  assign sel_bad = (sel_addr >= ADDR_W'(MEM_BYTES));
`else
  assign sel_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      bad_q      <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_funct3 <= 3'b000;
      r0.rvalid  <= 1'b0;
      r0.rdata   <= '0;
      r1.rvalid  <= 1'b0;
      r1.rdata   <= '0;
`ifdef DMEM_ARB_ADDR_CHECK_EN
      err        <= 1'b0;
`endif
    end else begin
      // Memory drives and pulses default back to idle every cycle.
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_funct3 <= 3'b000;
      r0.rvalid  <= 1'b0;
      r1.rvalid  <= 1'b0;
`ifdef DMEM_ARB_ADDR_CHECK_EN
      err        <= 1'b0;
`endif
      case (state)
        // Stage boundary: accept -> ISSUE (memory drive registered here)
        IDLE: begin
          if (accept) begin
            last_grant <= win_id;
            gid_q      <= win_id;
            we_q       <= sel_we;
            bad_q      <= sel_bad;
            busy       <= 1'b1;
            state      <= ISSUE;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            mem_funct3 <= sel_funct3;
            mem_read   <= !sel_we && !sel_bad;
            mem_write  <= sel_we && !sel_bad;
`ifdef DMEM_ARB_ADDR_CHECK_EN
            // A rejected store reports its error during the ISSUE cycle.
            err        <= sel_we && sel_bad;
`endif
          end
        end
        // Stage boundary: ISSUE -> WAIT for loads, back to IDLE otherwise
        ISSUE: begin
          if (we_q || bad_q) begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef DMEM_ARB_ADDR_CHECK_EN
            // A rejected load completes early with zero data.
            if (bad_q && !we_q) begin
              err <= 1'b1;
              if (gid_q) begin
                r1.rvalid <= 1'b1;
                r1.rdata  <= '0;
              end else begin
                r0.rvalid <= 1'b1;
                r0.rdata  <= '0;
              end
            end
`endif
          end else begin
            state <= WAIT;
          end
        end
        // Stage boundary: WAIT -> IDLE, memory read data captured here
        WAIT: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (gid_q) begin
            r1.rvalid <= 1'b1;
            r1.rdata  <= mem_rdata;
          end else begin
            r0.rvalid <= 1'b1;
            r0.rdata  <= mem_rdata;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. It includes a byte-addressed behavioural
// data memory that implements funct3 000 (signed byte) and returns registered
// read data. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;
  logic        busy;
`ifdef DMEM_ARB_ADDR_CHECK_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) u_r0 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) u_r1 ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .r0         (u_r0),
    .r1         (u_r1),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
`ifdef DMEM_ARB_ADDR_CHECK_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: 256 bytes, signed-byte loads, registered read data.
  logic [7:0] mem_b [0:255];
  always @(posedge clk) begin
    if (mem_write) mem_b[mem_addr[7:0]] <= mem_wdata[7:0];
    if (mem_read)  mem_rdata <= {{24{mem_b[mem_addr[7:0]][7]}}, mem_b[mem_addr[7:0]]};
    else           mem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? u_r0.ready : u_r1.ready;
  endfunction

  function automatic logic rv(input int id);
    return (id == 0) ? u_r0.rvalid : u_r1.rvalid;
  endfunction

  function automatic logic [31:0] rd(input int id);
    return (id == 0) ? u_r0.rdata : u_r1.rdata;
  endfunction

  task automatic set_req(input int id, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (id == 0) begin
      u_r0.valid = v; u_r0.we = we; u_r0.addr = addr; u_r0.wdata = wdata; u_r0.funct3 = FUNCT3_BYTE;
    end else begin
      u_r1.valid = v; u_r1.we = we; u_r1.addr = addr; u_r1.wdata = wdata; u_r1.funct3 = FUNCT3_BYTE;
    end
  endtask

  // Raise valid and wait (bounded) until ready, then take the accept edge.
  task automatic accept_req(input int id, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input string tag);
    set_req(id, 1'b1, we, addr, wdata);
    #1;
    for (int i = 0; i < 10 && !rdy(id); i++) tick();
    check({tag, " ready"}, {31'd0, rdy(id)}, 32'd1);
    tick();
    set_req(id, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_store(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                          input string tag);
    accept_req(id, 1'b1, addr, wdata, tag);
    check({tag, " issue mem_write"}, {31'd0, mem_write}, 32'd1);
    check({tag, " issue mem_read"},  {31'd0, mem_read},  32'd0);
    check({tag, " issue mem_addr"},  mem_addr,  addr);
    check({tag, " issue mem_wdata"}, mem_wdata, wdata);
    tick();
    check({tag, " post mem_write"},  {31'd0, mem_write}, 32'd0);
    check({tag, " post busy"},       {31'd0, busy},      32'd0);
    check({tag, " post mem_addr"},   mem_addr,           32'd0);
    check({tag, " no rvalid"},       {31'd0, rv(id)},    32'd0);
  endtask

  task automatic do_load(input int id, input logic [31:0] addr, input logic [31:0] exp,
                         input string tag);
    accept_req(id, 1'b0, addr, 32'd0, tag);
    check({tag, " issue mem_read"},  {31'd0, mem_read},  32'd1);
    check({tag, " issue mem_write"}, {31'd0, mem_write}, 32'd0);
    check({tag, " issue mem_addr"},  mem_addr, addr);
    check({tag, " issue busy"},      {31'd0, busy},      32'd1);
    tick();
    check({tag, " wait mem_read"},   {31'd0, mem_read},  32'd0);
    check({tag, " wait rvalid"},     {31'd0, rv(id)},    32'd0);
    tick();
    check({tag, " rvalid"},          {31'd0, rv(id)},    32'd1);
    check({tag, " rdata"},           rd(id),             exp);
    check({tag, " done busy"},       {31'd0, busy},      32'd0);
    tick();
    check({tag, " rvalid pulse"},    {31'd0, rv(id)},    32'd0);
    check({tag, " rdata hold"},      rd(id),             exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;
    reset = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(); tick();
    check("reset busy",      {31'd0, busy},      32'd0);
    check("reset mem_read",  {31'd0, mem_read},  32'd0);
    check("reset mem_write", {31'd0, mem_write}, 32'd0);
    check("reset r0_rdata",  u_r0.rdata,         32'd0);
    reset = 1'b1;
    tick();

    // Store then signed-byte load of a negative byte.
    do_store(0, 32'd5, 32'h0000_00A5, "st5");
    do_load (0, 32'd5, 32'hFFFF_FFA5, "ld5");

    // Positive byte and an untouched neighbour.
    do_store(0, 32'h13, 32'h0000_007F, "st13");
    do_load (0, 32'h13, 32'h0000_007F, "ld13");
    do_load (0, 32'h12, 32'h0000_0000, "ld12");

    // Reset during a load: the in-flight transaction is dropped.
    accept_req(0, 1'b0, 32'd5, 32'd0, "rst_ld");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst r0_rvalid",  {31'd0, u_r0.rvalid}, 32'd0);
      check("rst busy",       {31'd0, busy},        32'd0);
      check("rst mem_read",   {31'd0, mem_read},    32'd0);
      check("rst mem_addr",   mem_addr,             32'd0);
    end
    reset = 1'b1;
    tick();
    check("post-rst r0_rvalid", {31'd0, u_r0.rvalid}, 32'd0);

    // Both requesters loading continuously: r0 first after reset, then alternate.
    set_req(0, 1'b1, 1'b0, 32'd5,  32'd0);
    set_req(1, 1'b1, 1'b0, 32'h13, 32'd0);
    #1;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = k % 2;
      check("rr winner ready", {31'd0, rdy(w)},     32'd1);
      check("rr loser ready",  {31'd0, rdy(1 - w)}, 32'd0);
      tick();
      tick();
      tick();
      check("rr winner rvalid", {31'd0, rv(w)},     32'd1);
      check("rr loser rvalid",  {31'd0, rv(1 - w)}, 32'd0);
      check("rr rdata", rd(w), (w == 0) ? 32'hFFFF_FFA5 : 32'h0000_007F);
      if (k == 3) begin
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
      end
    end
    tick();

    // r1 load arrives while an r0 store is in ISSUE.
    set_req(0, 1'b1, 1'b1, 32'd8, 32'h0000_0080);
    #1;
    check("t4 r0 ready", {31'd0, u_r0.ready}, 32'd1);
    tick();
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b1, 1'b0, 32'd8, 32'd0);
    #1;
    check("t4 r1 ready in ISSUE", {31'd0, u_r1.ready}, 32'd0);
    check("t4 store mem_write",   {31'd0, mem_write},  32'd1);
    tick();
    check("t4 r1 ready in IDLE",  {31'd0, u_r1.ready}, 32'd1);
    tick();
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    check("t4 mem_read",  {31'd0, mem_read}, 32'd1);
    check("t4 mem_addr",  mem_addr,          32'd8);
    tick();
    tick();
    check("t4 r1 rvalid", {31'd0, u_r1.rvalid}, 32'd1);
    check("t4 r1 rdata",  u_r1.rdata,           32'hFFFF_FF80);
    check("t4 r0 rvalid", {31'd0, u_r0.rvalid}, 32'd0);
    tick();

`ifdef DMEM_ARB_ADDR_CHECK_EN
    // Out-of-range load: never issued, early zero completion with err.
    u_r0.rdata = u_r0.rdata;
    accept_req(0, 1'b0, 32'h100, 32'd0, "oor_ld");
    check("oor issue mem_read", {31'd0, mem_read},    32'd0);
    check("oor issue err",      {31'd0, err},         32'd0);
    tick();
    check("oor rvalid",         {31'd0, u_r0.rvalid}, 32'd1);
    check("oor rdata",          u_r0.rdata,           32'd0);
    check("oor err",            {31'd0, err},         32'd1);
    check("oor mem_read",       {31'd0, mem_read},    32'd0);
    tick();
    check("oor err pulse",      {31'd0, err},         32'd0);
    // Out-of-range store: err during the ISSUE cycle, no write.
    accept_req(0, 1'b1, 32'h200, 32'h11, "oor_st");
    check("oor st err",         {31'd0, err},         32'd1);
    check("oor st mem_write",   {31'd0, mem_write},   32'd0);
    tick();
    check("oor st err pulse",   {31'd0, err},         32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
